// File: rtl/mesi_line_controller.sv
// mesi_line_controller
//   Sequences one MESI coherence update for a single cache line. The
//   processor presents the selected way (tag/MESI/LRU) along with a trace
//   op; the controller performs any bus traffic (victim writeback, fill,
//   invalidate, snoop writeback) and returns the updated line with a
//   one-cycle done pulse.
//
//   state  | meaning
//   -------+----------------------------------------------------------
//   IDLE   | ready for a command (cmd_ready=1)
//   WB     | victim writeback WRITE on the bus, waiting for bus_ack
//   BUS    | fill / invalidate / snoop-writeback request, waiting for ack
//   UPDATE | done pulse, returned line valid
//
// Ports
//   clk, rst                        clock, async active-high reset
//   cmd_valid/cmd_ready             command handshake
//   cmd_n, cmd_tag, hit_i           trace op, requested tag, way tag match
//   line_tag_i/mesi_i/lru_i         selected way as currently held
//   line_tag_o/mesi_o/lru_o, done   updated line, valid with done
//   bus_req/bus_op/bus_tag          bus request (0 READ,1 WRITE,2 INV,3 RWIM)
//   bus_ack/snoop_rsp               ack and snoop result (0 HIT,1 HITM,2 NOHIT)
//   err                             abort flag, pulses with done
//
// Build option
//   BUS_TIMEOUT_EN  enables the bus-ack watchdog (TIMEOUT cycles); without
//                   it the controller waits indefinitely and err is 0.

module mesi_line_controller #(
   parameter int TAG_W   = 12,
   parameter int TIMEOUT = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [3:0]       cmd_n,
   input  logic [TAG_W-1:0] cmd_tag,
   input  logic             hit_i,
   input  logic [TAG_W-1:0] line_tag_i,
   input  logic [1:0]       line_mesi_i,
   input  logic [2:0]       line_lru_i,
   output logic [TAG_W-1:0] line_tag_o,
   output logic [1:0]       line_mesi_o,
   output logic [2:0]       line_lru_o,
   output logic             done,
   output logic             bus_req,
   output logic [1:0]       bus_op,
   output logic [TAG_W-1:0] bus_tag,
   input  logic             bus_ack,
   input  logic [1:0]       snoop_rsp,
   output logic             err
);

   if (TIMEOUT < 1) begin : g_timeout_check
      $error("mesi_line_controller: TIMEOUT must be at least 1");
   end

   localparam logic [1:0] MESI_I = 2'd0;
   localparam logic [1:0] MESI_S = 2'd1;
   localparam logic [1:0] MESI_E = 2'd2;
   localparam logic [1:0] MESI_M = 2'd3;

   localparam logic [1:0] BUS_READ  = 2'd0;
   localparam logic [1:0] BUS_WRITE = 2'd1;
   localparam logic [1:0] BUS_INV   = 2'd2;
   localparam logic [1:0] BUS_RWIM  = 2'd3;

   localparam logic [1:0] SNP_NOHIT = 2'd2;

   localparam logic [3:0] OP_RD    = 4'd0;
   localparam logic [3:0] OP_WR    = 4'd1;
   localparam logic [3:0] OP_IF    = 4'd2;
   localparam logic [3:0] OP_L2INV = 4'd3;
   localparam logic [3:0] OP_SNP   = 4'd4;
   localparam logic [3:0] OP_CLR   = 4'd8;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WB     = 2'd1,
      ST_BUS    = 2'd2,
      ST_UPDATE = 2'd3
   } state_t;

   typedef struct packed {
      logic [TAG_W-1:0] tag;
      logic [1:0]       mesi;
      logic [2:0]       lru;
   } line_t;

   state_t           state_q, state_d;
   logic [3:0]       op_q, op_d;
   logic [TAG_W-1:0] tag_q, tag_d;
   logic             hit_q, hit_d;
   line_t            held_q, held_d;
   logic [1:0]       fill_op_q, fill_op_d;
   line_t            line_q, line_d;

   line_t            held_in;
   logic             acc_hit;
   logic             need_wb;
   logic             need_fill;
   logic [1:0]       fill_op;
   logic             timeout;

   // Resulting line for a completed transaction. For op 0/2 the snoop
   // response only matters on a miss (the fill decides S vs E).
   function automatic line_t line_result(input logic [3:0]       op,
                                         input logic             hit,
                                         input logic [TAG_W-1:0] req_tag,
                                         input line_t            held,
                                         input logic [1:0]       snoop);
      line_t r;
      r = held;
      case (op)
         OP_RD, OP_IF: begin
            r.tag = req_tag;
            r.lru = 3'd0;
            if (!hit) r.mesi = (snoop == SNP_NOHIT) ? MESI_E : MESI_S;
         end
         OP_WR: begin
            r.tag  = req_tag;
            r.lru  = 3'd0;
            r.mesi = MESI_M;
         end
         OP_L2INV: begin
            if (held.mesi == MESI_S) r.mesi = MESI_I;
         end
         OP_SNP: begin
            if (held.mesi == MESI_M || held.mesi == MESI_E) r.mesi = MESI_S;
         end
         OP_CLR: begin
            r.tag  = '0;
            r.mesi = MESI_I;
         end
         default: ;
      endcase
      return r;
   endfunction

   assign cmd_ready = (state_q == ST_IDLE) && !rst;

   always_comb begin
      held_in.tag  = line_tag_i;
      held_in.mesi = line_mesi_i;
      held_in.lru  = line_lru_i;
   end

   // Bus work implied by an incoming command.
   always_comb begin
      acc_hit   = hit_i && (line_mesi_i != MESI_I);
      need_wb   = 1'b0;
      need_fill = 1'b0;
      fill_op   = BUS_READ;
      case (cmd_n)
         OP_RD, OP_IF: begin
            if (!acc_hit) begin
               need_fill = 1'b1;
               fill_op   = BUS_READ;
               need_wb   = (line_mesi_i == MESI_M);
            end
         end
         OP_WR: begin
            if (acc_hit) begin
               if (line_mesi_i == MESI_S) begin
                  need_fill = 1'b1;
                  fill_op   = BUS_INV;
               end
            end else begin
               need_fill = 1'b1;
               fill_op   = BUS_RWIM;
               need_wb   = (line_mesi_i == MESI_M);
            end
         end
         OP_SNP: begin
            if (line_mesi_i == MESI_M) begin
               need_fill = 1'b1;
               fill_op   = BUS_WRITE;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      tag_d     = tag_q;
      hit_d     = hit_q;
      held_d    = held_q;
      fill_op_d = fill_op_q;
      line_d    = line_q;
      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               op_d      = cmd_n;
               tag_d     = cmd_tag;
               hit_d     = acc_hit;
               held_d    = held_in;
               fill_op_d = fill_op;
               if (need_wb) begin
                  state_d = ST_WB;
               end else if (need_fill) begin
                  state_d = ST_BUS;
               end else begin
                  state_d = ST_UPDATE;
                  line_d  = line_result(cmd_n, acc_hit, cmd_tag, held_in, SNP_NOHIT);
               end
            end
         end
         ST_WB: begin
            if (bus_ack) begin
               state_d = ST_BUS;
            end else if (timeout) begin
               state_d = ST_UPDATE;
               line_d  = held_q;
            end
         end
         ST_BUS: begin
            if (bus_ack) begin
               state_d = ST_UPDATE;
               line_d  = line_result(op_q, hit_q, tag_q, held_q, snoop_rsp);
            end else if (timeout) begin
               state_d = ST_UPDATE;
               line_d  = held_q;
            end
         end
         ST_UPDATE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         op_q      <= '0;
         tag_q     <= '0;
         hit_q     <= 1'b0;
         held_q    <= '0;
         fill_op_q <= '0;
         line_q    <= '0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         tag_q     <= tag_d;
         hit_q     <= hit_d;
         held_q    <= held_d;
         fill_op_q <= fill_op_d;
         line_q    <= line_d;
      end
   end

   // Bus outputs come straight from state so they drop the cycle after ack
   // and read as zero whenever no request is open (including under reset).
   always_comb begin
      bus_req = 1'b0;
      bus_op  = BUS_READ;
      bus_tag = '0;
      if (state_q == ST_WB) begin
         bus_req = 1'b1;
         bus_op  = BUS_WRITE;
         bus_tag = held_q.tag;
      end else if (state_q == ST_BUS) begin
         bus_req = 1'b1;
         bus_op  = fill_op_q;
         bus_tag = tag_q;
      end
   end

   assign done        = (state_q == ST_UPDATE);
   assign line_tag_o  = line_q.tag;
   assign line_mesi_o = line_q.mesi;
   assign line_lru_o  = line_q.lru;

`ifdef BUS_TIMEOUT_EN
   localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT - 1);

   logic [WD_W-1:0] wd_q, wd_d;
   logic            err_q, err_d;

   // Down-counter reloads whenever no request is waiting (idle or on ack),
   // so each request gets a fresh TIMEOUT-cycle window; terminal count 0
   // on an unacked request cycle is the timeout.
   assign timeout = bus_req && !bus_ack && (wd_q == '0);

   always_comb begin
      wd_d = wd_q;
      if (!bus_req || bus_ack) begin
         wd_d = WD_LOAD;
      end else if (wd_q != '0) begin
         wd_d = wd_q - 1'b1;
      end
      err_d = timeout;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wd_q  <= '0;
         err_q <= 1'b0;
      end else begin
         wd_q  <= wd_d;
         err_q <= err_d;
      end
   end

   assign err = err_q;
`else
   assign timeout = 1'b0;
   assign err     = 1'b0;
`endif

endmodule

// File: doc/mesi_line_controller.md
MESI_LINE_CONTROLLER -- requirements
Module: mesi_line_controller

Interface
REQ-001 SHALL have parameter TAG_W, default 12, meaning address tag width.
REQ-002 SHALL have parameter TIMEOUT, default 16, meaning bus-ack watchdog limit in cycles (used only under REQ-032).
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port cmd_valid  input  1  command present.
REQ-006 SHALL have port cmd_ready  output  1  controller can accept a command.
REQ-007 SHALL have port cmd_n  input  4  trace op: 0 data read, 1 data write, 2 ifetch, 3 L2 invalidate, 4 snooped read, 8 clear, 9 print.
REQ-008 SHALL have port cmd_tag  input  TAG_W  requested tag.
REQ-009 SHALL have port hit_i  input  1  processor reports tag match in selected way.
REQ-010 SHALL have ports line_tag_i/line_mesi_i/line_lru_i  input  TAG_W/2/3  selected way as held, i.e. victim's original tag, MESI (I=00,S=01,E=10,M=11) and LRU.
REQ-011 SHALL have ports line_tag_o/line_mesi_o/line_lru_o  output  TAG_W/2/3  updated line returned to processor.
REQ-012 SHALL have port done  output  1  one-cycle pulse; line_*_o valid.
REQ-013 SHALL have ports bus_req/bus_op/bus_tag  output  1/2/TAG_W  bus request; op 0 READ, 1 WRITE, 2 INVALIDATE, 3 RWIM.
REQ-014 SHALL have ports bus_ack/snoop_rsp  input  1/2  request accepted; snoop result on ack cycle (0 HIT, 1 HITM, 2 NOHIT).
REQ-015 SHALL have port err  output  1  set with done when a transaction was aborted.

Function
REQ-016 SHALL implement states IDLE, WB, BUS, UPDATE; cmd_ready=1 only in IDLE with rst low.
REQ-017 SHALL accept a command on a cycle with cmd_valid & cmd_ready, latching cmd_n, cmd_tag, hit_i, line_*_i; cmd_valid in other states is ignored.
REQ-018 SHALL treat a hit as hit_i=1 and line_mesi_i!=I.
REQ-019 Ops 0/2: hit -> MESI unchanged, no bus; miss -> WB if victim M, then READ on cmd_tag; snoop HIT/HITM -> S, NOHIT -> E.
REQ-020 Op 1: hit M/E -> M, no bus; hit S -> INVALIDATE then M; miss -> WB if victim M, then RWIM, -> M.
REQ-021 Op 3: S -> I, other states unchanged, no bus.
REQ-022 Op 4: M -> WRITE (writeback) then S; E -> S; S and I unchanged.
REQ-023 Op 8: returns MESI=I, tag=0, LRU unchanged, no bus; op 9 and undefined ops return line unchanged, no bus.
REQ-024 WB SHALL issue WRITE with bus_tag=latched line_tag_i; all other ops SHALL use bus_tag=latched cmd_tag.
REQ-025 bus_req, bus_op, bus_tag SHALL be held stable from assertion until the bus_ack cycle and deassert the cycle after; bus_ack with bus_req low is ignored.
REQ-026 After WB ack, the fill request SHALL assert the very next cycle.
REQ-027 Returned line_tag_o SHALL be cmd_tag for ops 0/1/2, else latched tag (except op 8); line_lru_o SHALL be 0 for ops 0/1/2, else latched LRU.
REQ-028 Latency: no-bus op accepted at cycle T -> done at T+1; bus op -> done one cycle after final bus_ack.
REQ-029 line_*_o SHALL hold last value until next done; done SHALL never assert in consecutive cycles.

Reset
REQ-030 rst SHALL immediately force IDLE, all outputs 0 (line outputs, done, bus_req, bus_op, bus_tag, err, cmd_ready), watchdog cleared.
REQ-031 rst mid-transaction SHALL abort with no done pulse; first command accepted on first rising edge after rst falls.

Configuration
REQ-032 With BUS_TIMEOUT_EN defined, a counter SHALL count cycles with bus_req high and no ack; at TIMEOUT it SHALL drop bus_req, pulse done with err=1, return latched line unchanged, go IDLE.
REQ-033 Without BUS_TIMEOUT_EN, the controller SHALL wait indefinitely for bus_ack and err SHALL be tied 0.

Verification
REQ-034 Op 0, hit_i=0, victim I, snoop NOHIT, ack 3 cycles after req -> one READ on cmd_tag, done next cycle, MESI=E, LRU=0.
REQ-035 Op 1, hit_i=0, victim M tag 0x0AB, cmd_tag 0x123 -> WRITE tag 0x0AB, then RWIM tag 0x123 next cycle after ack, MESI=M.
REQ-036 Op 1, hit, S -> INVALIDATE then M; same with E -> no bus_req, done at T+1, MESI=M.
REQ-037 Op 4 on M line -> WRITE then S; op 3 on S -> I at T+1; op 8 -> tag 0, MESI=I.
REQ-038 rst asserted while bus_req high awaiting ack -> outputs 0 immediately, no done; cmd_valid back-to-back during BUS ignored.
REQ-039 BUS_TIMEOUT_EN defined, bus_ack never asserted -> done with err=1 after 16 cycles of bus_req, line unchanged.
